mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Two-client arbiter and sequencer sharing one 8×8 handshake multiplier unit (the `dav_`/`rfd` operand, `ok` result unit of `mul_8`). Each client presents an operand pair through its own `dav_`/`rfd` handshake. The arbiter grants one client at a time, replays the operands into the shared multiplier, and returns the product with a one-cycle `ok` pulse on that client's port. The block sits between the client producers and a single multiplier instance, so the multiplier area is not duplicated.

## Interface
- `W`, default 8: operand width; products are `2*W` bits.
- `clock` in 1: sole clock, rising edge.
- `reset_` in 1: asynchronous, active-low reset.
- `xa`, `ya` in W: client A operands, valid while `dava_`=0.
- `dava_` in 1: client A data-available, active low.
- `rfda` out 1: client A ready-for-data.
- `ma` out 2W: client A last product, registered.
- `oka` out 1: one-cycle pulse, `ma` valid.
- `xb`, `yb`, `davb_`, `rfdb`, `mb`, `okb`: the same set for client B.
- `mul_x`, `mul_y` out W: operands to the multiplier, registered.
- `mul_dav_` out 1: data-available to the multiplier, active low.
- `mul_rfd` in 1: ready-for-data from the multiplier.
- `mul_m` in 2W: multiplier product.
- `mul_ok` in 1: product valid; held high ≥1 cycle.

## Operation
- A client k is pending when `rfdk`=1 and `davk_`=0 at a rising edge.
- Arbitration:
  - Default policy is round-robin on a `last_grant` register. With both clients pending, the grant goes to the client that is not `last_grant`.
  - `last_grant` resets to B, so A wins the first tie.
- FSM states: IDLE, ISSUE, RELEASE, WAIT_OK, WAIT_OKL.
  - IDLE, with a client pending: latch that client's x,y into `mul_x`/`mul_y`; `rfdk`←0; `mul_dav_`←0; `last_grant`←k; go to ISSUE.
  - ISSUE, `mul_rfd`=0: `mul_dav_`←1; go to RELEASE.
  - RELEASE, `mul_rfd`=1: go to WAIT_OK.
  - WAIT_OK, `mul_ok`=1: `mk`←`mul_m`; `okk`←1 for exactly one cycle; go to WAIT_OKL.
  - WAIT_OKL, `mul_ok`=0: go to IDLE.
  - In every other case the FSM holds its state.
- Client `rfdk` is released by a per-client done flag. `rfdk`←1 at the first edge where `okk` has been issued and `davk_`=1 are both true, in either order. Each client has at most one operation outstanding.
- After `rfdk` falls, the client may change x,y, because the operands are already latched.
- While `rfdk`=0, the client's `davk_` is ignored.
- `mk` holds its value until that client's next result. The other client's `m` and `ok` never change.
- Arithmetic: the product is passed through unmodified. The multiplier guarantees `mul_m` = x*y, 2W bits, with no truncation.

## Timing
- Reset values: `rfda`=`rfdb`=1; `oka`=`okb`=0; `ma`=`mb`=0; `mul_dav_`=1; `mul_x`=`mul_y`=0; state IDLE; `last_grant`=B; done flags 0.
- A request sampled pending at edge n produces `rfdk`=0, `mul_dav_`=0 and valid `mul_x`/`mul_y` after edge n.
- `okk` rises 1 edge after `mul_ok` is first sampled high.
- An idle arbiter adds 3 cycles plus the multiplier latency per operation.
- Back-to-back issue: the next IDLE grant can occur 1 cycle after `mul_ok` falls.
- Simultaneous events:
  - Both clients pending in the same cycle: a single grant by policy; the loser keeps `rfd`=1 and is granted at the next IDLE.
  - `davk_` rising during ISSUE/RELEASE: legal, no effect on the sequence.
- Reset mid-operation: all registers return to reset values immediately. No `ok` pulse is produced and the in-flight result is lost. The multiplier shares `reset_`.

## Configuration
- `MUL_ARB_FIXED_PRIO_EN` defined: fixed priority, A over B. B is granted only in an IDLE cycle where A is not pending, and `last_grant` is not used.
- Undefined (default): round-robin as above.

## Structure
- Shared package `mul_arb_pkg` holds:
  - the FSM state enum `mul_arb_state_t`;
  - the client index type `mul_arb_client_t` (A=0, B=1);
  - the default width localparam.
- Sub-module `mul_arb_port`, instantiated twice, owns one client's `rfd`, done flag, `m` register and `ok` pulse.
- The top level holds the FSM, the arbitration logic and the multiplier-side registers.

## Test plan
- Reset: hold `reset_`=0, then release → `rfda`=`rfdb`=1, `oka`=`okb`=0, `mul_dav_`=1, `ma`=`mb`=0.
- Single request A x=5,y=28 with a behavioural multiplier model → `mul_x`=5 and `mul_y`=28 while `mul_dav_`=0; `ma`=140 with a one-cycle `oka`; `rfda` returns to 1 only after `dava_`=1; B signals unchanged.
- A (10,35) and B (15,42) pending on the same edge → A served first with `ma`=350, then B with `mb`=630.
- Under continuous contention, grants alternate A,B,A,B.
- With `MUL_ARB_FIXED_PRIO_EN` and A re-requesting immediately each time → B is granted only in an IDLE cycle with no A request; results remain correct.
- Assert `reset_`=0 while in WAIT_OK for client B → no `okb` pulse, `rfdb`=1, `mul_dav_`=1, state IDLE. The next request (20,49) → `m`=980.
- Random stream: 60 cases per client (x=(i[5:2]+1)*5, y=(i[1:0]+4)*7) with random handshake and multiplier delays → every product matches, and exactly one `ok` pulse per request on the correct port.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types for the two-client multiplier arbiter: FSM states, client index, default width.

package mul_arb_pkg;

   localparam int MUL_ARB_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RELEASE,
      ST_WAIT_OK,
      ST_WAIT_OKL
   } mul_arb_state_t;

   typedef enum logic {
      CLIENT_A = 1'b0,
      CLIENT_B = 1'b1
   } mul_arb_client_t;

endpackage

// File: rtl/mul_arb_port.sv
// One client port: rfd drop on grant, product register with one-cycle ok pulse.
// rfd only rises after the result has been delivered and the client has let dav_ go high.

module mul_arb_port
   import mul_arb_pkg::*;
#(
   parameter int W = MUL_ARB_W
) (
   input  logic           clock,
   input  logic           reset_,
   input  logic           grant,
   input  logic           load,
   input  logic           dav_,
   input  logic [2*W-1:0] mul_m,
   output logic           rfd,
   output logic [2*W-1:0] m,
   output logic           ok
);

   logic done;

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         rfd  <= 1'b1;
         done <= 1'b0;
         m    <= '0;
         ok   <= 1'b0;
      end else begin
         ok <= load;
         if (load) begin
            m    <= mul_m;
            done <= 1'b1;
         end
         // done is set on the load edge, so ok is already visible when the release fires
         if (grant) begin
            rfd  <= 1'b0;
            done <= 1'b0;
         end else if (done && dav_) begin
            rfd  <= 1'b1;
            done <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mul_arbiter.sv
// Two-client arbiter sharing one dav_/rfd multiplier; grant lands one edge after a client is pending.
// Define MUL_ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.

module mul_arbiter
   import mul_arb_pkg::*;
#(
   parameter int W = MUL_ARB_W
) (
   input  logic           clock,
   input  logic           reset_,
   input  logic [W-1:0]   xa,
   input  logic [W-1:0]   ya,
   input  logic           dava_,
   output logic           rfda,
   output logic [2*W-1:0] ma,
   output logic           oka,
   input  logic [W-1:0]   xb,
   input  logic [W-1:0]   yb,
   input  logic           davb_,
   output logic           rfdb,
   output logic [2*W-1:0] mb,
   output logic           okb,
   output logic [W-1:0]   mul_x,
   output logic [W-1:0]   mul_y,
   output logic           mul_dav_,
   input  logic           mul_rfd,
   input  logic [2*W-1:0] mul_m,
   input  logic           mul_ok
);

   mul_arb_state_t  state, state_nxt;
   mul_arb_client_t sel, cur;
   logic            pend_a, pend_b, grant, load;
`ifndef MUL_ARB_FIXED_PRIO_EN
   mul_arb_client_t last_grant;
`endif

   assign pend_a = rfda & ~dava_;
   assign pend_b = rfdb & ~davb_;

   always_comb begin
`ifdef MUL_ARB_FIXED_PRIO_EN
      sel = pend_a ? CLIENT_A : CLIENT_B;
`else
      if (pend_a && pend_b)
         sel = (last_grant == CLIENT_A) ? CLIENT_B : CLIENT_A;
      else
         sel = pend_a ? CLIENT_A : CLIENT_B;
`endif
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pend_a || pend_b) begin
               grant     = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE:    if (!mul_rfd) state_nxt = ST_RELEASE;
         ST_RELEASE:  if (mul_rfd)  state_nxt = ST_WAIT_OK;
         ST_WAIT_OK: begin
            if (mul_ok) begin
               load      = 1'b1;
               state_nxt = ST_WAIT_OKL;
            end
         end
         ST_WAIT_OKL: if (!mul_ok)  state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         mul_x      <= '0;
         mul_y      <= '0;
         mul_dav_   <= 1'b1;
         cur        <= CLIENT_A;
`ifndef MUL_ARB_FIXED_PRIO_EN
         last_grant <= CLIENT_B;
`endif
      end else if (grant) begin
         mul_x      <= (sel == CLIENT_A) ? xa : xb;
         mul_y      <= (sel == CLIENT_A) ? ya : yb;
         mul_dav_   <= 1'b0;
         cur        <= sel;
`ifndef MUL_ARB_FIXED_PRIO_EN
         last_grant <= sel;
`endif
      end else if (state == ST_ISSUE && !mul_rfd) begin
         mul_dav_   <= 1'b1;
      end
   end

   mul_arb_port #(.W(W)) u_port_a (
      .clock  (clock),
      .reset_ (reset_),
      .grant  (grant && (sel == CLIENT_A)),
      .load   (load && (cur == CLIENT_A)),
      .dav_   (dava_),
      .mul_m  (mul_m),
      .rfd    (rfda),
      .m      (ma),
      .ok     (oka)
   );

   mul_arb_port #(.W(W)) u_port_b (
      .clock  (clock),
      .reset_ (reset_),
      .grant  (grant && (sel == CLIENT_B)),
      .load   (load && (cur == CLIENT_B)),
      .dav_   (davb_),
      .mul_m  (mul_m),
      .rfd    (rfdb),
      .m      (mb),
      .ok     (okb)
   );

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: behavioural dav_/rfd multiplier, per-client scoreboards and an arbitration reference.

module tb_mul_arbiter;
   import mul_arb_pkg::*;

   localparam int W = 8;

   logic           clock = 1'b0;
   logic           reset_;
   logic [W-1:0]   xa, ya, xb, yb;
   logic           dava_, davb_;
   logic           rfda, rfdb, oka, okb;
   logic [2*W-1:0] ma, mb;
   logic [W-1:0]   mul_x, mul_y;
   logic           mul_dav_;
   logic           mul_rfd, mul_ok;
   logic [2*W-1:0] mul_m;

   mul_arbiter #(.W(W)) dut (
      .clock(clock), .reset_(reset_),
      .xa(xa), .ya(ya), .dava_(dava_), .rfda(rfda), .ma(ma), .oka(oka),
      .xb(xb), .yb(yb), .davb_(davb_), .rfdb(rfdb), .mb(mb), .okb(okb),
      .mul_x(mul_x), .mul_y(mul_y), .mul_dav_(mul_dav_),
      .mul_rfd(mul_rfd), .mul_m(mul_m), .mul_ok(mul_ok)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   logic [2*W-1:0] exp_a[$], exp_b[$];
   logic [W-1:0]   req_xa, req_ya, req_xb, req_yb;
   logic           hold_ok = 1'b0;

   // Behavioural multiplier: accept, wait for dav_ release, raise rfd, then ok for 1..3 cycles.
   int             mst, mcnt;
   logic [W-1:0]   lx, ly;
   always @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         mul_rfd <= 1'b1; mul_ok <= 1'b0; mul_m <= '0; mst <= 0; mcnt <= 0;
      end else begin
         case (mst)
            0: if (!mul_dav_ && mul_rfd) begin
                  lx <= mul_x; ly <= mul_y; mul_rfd <= 1'b0; mst <= 1;
               end
            1: if (mul_dav_) begin mcnt <= int'($urandom_range(0, 3)); mst <= 2; end
            2: if (mcnt == 0) begin
                  mul_rfd <= 1'b1; mcnt <= int'($urandom_range(0, 3)); mst <= 3;
               end else mcnt <= mcnt - 1;
            3: if (!hold_ok) begin
                  if (mcnt == 0) begin
                     mul_ok <= 1'b1; mul_m <= 16'(lx) * 16'(ly);
                     mcnt <= int'($urandom_range(0, 2)); mst <= 4;
                  end else mcnt <= mcnt - 1;
               end
            default: if (mcnt == 0) begin mul_ok <= 1'b0; mst <= 0; end
                     else mcnt <= mcnt - 1;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: grant order, latched operands, products, ok width, result hold.
   logic           prev_rfda, prev_rfdb, pa, pb, prev_oka, prev_okb;
   logic [2*W-1:0] prev_ma, prev_mb, e;
   int             tb_last, expw, got;
   always @(negedge clock) begin
      if (!reset_) begin
         exp_a.delete(); exp_b.delete(); tb_last = 1;
         prev_rfda = 1'b1; prev_rfdb = 1'b1; pa = 1'b0; pb = 1'b0;
         prev_oka = 1'b0; prev_okb = 1'b0; prev_ma = '0; prev_mb = '0;
      end else begin
         if ((prev_rfda && !rfda) || (prev_rfdb && !rfdb)) begin
            got = (prev_rfda && !rfda && prev_rfdb && !rfdb) ? 2 : ((prev_rfda && !rfda) ? 0 : 1);
            if (!(pa || pb)) expw = -1;
`ifdef MUL_ARB_FIXED_PRIO_EN
            else expw = pa ? 0 : 1;
`else
            else if (pa && pb) expw = (tb_last == 0) ? 1 : 0;
            else expw = pa ? 0 : 1;
`endif
            chk("grant_client", got, expw);
            if (got < 2) tb_last = got;
            chk("grant_dav", {31'd0, mul_dav_}, 32'd0);
            chk("grant_x", mul_x, (got == 0) ? req_xa : req_xb);
            chk("grant_y", mul_y, (got == 0) ? req_ya : req_yb);
         end
         if (oka) begin
            if (exp_a.size() == 0) begin
               checks++; failures++;
               $display("FAIL oka_unexpected: got pulse with ma=%0d expected none", ma);
            end else begin
               e = exp_a.pop_front();
               chk("ma_product", ma, e);
            end
            chk("oka_width", {31'd0, prev_oka}, 32'd0);
         end else chk("ma_hold", ma, prev_ma);
         if (okb) begin
            if (exp_b.size() == 0) begin
               checks++; failures++;
               $display("FAIL okb_unexpected: got pulse with mb=%0d expected none", mb);
            end else begin
               e = exp_b.pop_front();
               chk("mb_product", mb, e);
            end
            chk("okb_width", {31'd0, prev_okb}, 32'd0);
         end else chk("mb_hold", mb, prev_mb);
         prev_rfda = rfda; prev_rfdb = rfdb; prev_oka = oka; prev_okb = okb;
         prev_ma = ma; prev_mb = mb;
         pa = rfda && !dava_;
         pb = rfdb && !davb_;
      end
   end

   function automatic logic rfd_of(input int c);
      return (c == 0) ? rfda : rfdb;
   endfunction

   task automatic wait_rfd(input int c, input logic lvl, output bit ok);
      int t = 0;
      ok = 1'b1;
      while (rfd_of(c) !== lvl) begin
         @(posedge clock); #1;
         t++;
         if (t > 3000) begin
            checks++; failures++; ok = 1'b0;
            $display("FAIL timeout_rfd: client %0d rfd stuck, expected %0d", c, lvl);
            return;
         end
      end
   endtask

   task automatic client_req(input int c, input logic [W-1:0] x, input logic [W-1:0] y,
                             input int hold_max);
      bit ok;
      @(posedge clock); #1;
      wait_rfd(c, 1'b1, ok);
      if (!ok) return;
      if (c == 0) begin
         req_xa = x; req_ya = y; xa = x; ya = y; dava_ = 1'b0;
         exp_a.push_back(16'(x) * 16'(y));
      end else begin
         req_xb = x; req_yb = y; xb = x; yb = y; davb_ = 1'b0;
         exp_b.push_back(16'(x) * 16'(y));
      end
      @(posedge clock); #1;
      wait_rfd(c, 1'b0, ok);
      if (!ok) return;
      if (c == 0) begin xa = W'($urandom); ya = W'($urandom); end
      else        begin xb = W'($urandom); yb = W'($urandom); end
      repeat ($urandom_range(0, hold_max)) @(posedge clock);
      #1;
      if (c == 0) dava_ = 1'b1; else davb_ = 1'b1;
      wait_rfd(c, 1'b1, ok);
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset_ = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_ = 1'b1;
   endtask

   task automatic stream(input int c);
      for (int i = 0; i < 60; i++) begin
         client_req(c, W'((((i >> 2) & 15) + 1) * 5), W'(((i & 3) + 4) * 7), 3);
         repeat ($urandom_range(0, 2)) @(posedge clock);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      reset_ = 1'b0; dava_ = 1'b1; davb_ = 1'b1;
      xa = '0; ya = '0; xb = '0; yb = '0;
      req_xa = '0; req_ya = '0; req_xb = '0; req_yb = '0;
      repeat (3) @(negedge clock);
      chk("rst_rfda", {31'd0, rfda}, 1); chk("rst_rfdb", {31'd0, rfdb}, 1);
      chk("rst_oka", {31'd0, oka}, 0);   chk("rst_okb", {31'd0, okb}, 0);
      chk("rst_mul_dav", {31'd0, mul_dav_}, 1);
      chk("rst_ma", ma, 0); chk("rst_mb", mb, 0);
      chk("rst_mul_x", mul_x, 0); chk("rst_mul_y", mul_y, 0);
      @(posedge clock); #1 reset_ = 1'b1;

      // Single A request, dav_ held low past the result to check rfd stays low.
      @(posedge clock); #1;
      req_xa = 8'd5; req_ya = 8'd28; xa = 8'd5; ya = 8'd28; dava_ = 1'b0;
      exp_a.push_back(16'd140);
      t = 0;
      while (!oka && t < 200) begin @(posedge clock); #1; t++; end
      chk("single_ok_seen", {31'd0, oka}, 1);
      chk("single_ma", ma, 140);
      repeat (3) @(posedge clock);
      #1 chk("single_rfda_held", {31'd0, rfda}, 0);
      dava_ = 1'b1;
      repeat (2) @(posedge clock);
      #1 chk("single_rfda_back", {31'd0, rfda}, 1);
      chk("single_rfdb", {31'd0, rfdb}, 1);
      chk("single_mb", mb, 0);

      // Simultaneous requests from a fresh reset: A wins the first tie.
      do_reset();
      fork
         client_req(0, 8'd10, 8'd35, 2);
         client_req(1, 8'd15, 8'd42, 2);
      join
      repeat (4) @(posedge clock);
      chk("tie_ma", ma, 350);
      chk("tie_mb", mb, 630);

      // Random contention stream on both ports.
      fork
         stream(0);
         stream(1);
      join
      repeat (10) @(posedge clock);

      // Reset while client B waits for its result.
      hold_ok = 1'b1;
      @(posedge clock); #1;
      req_xb = 8'd7; req_yb = 8'd9; xb = 8'd7; yb = 8'd9; davb_ = 1'b0;
      t = 0;
      while (rfdb && t < 200) begin @(posedge clock); #1; t++; end
      chk("midop_granted", {31'd0, rfdb}, 0);
      davb_ = 1'b1;
      repeat (12) @(posedge clock);
      #1 reset_ = 1'b0;
      @(negedge clock);
      chk("midop_rfdb", {31'd0, rfdb}, 1);
      chk("midop_okb", {31'd0, okb}, 0);
      chk("midop_mul_dav", {31'd0, mul_dav_}, 1);
      chk("midop_mb", mb, 0);
      @(posedge clock); #1;
      hold_ok = 1'b0;
      reset_ = 1'b1;
      client_req(1, 8'd20, 8'd49, 1);
      repeat (4) @(posedge clock);
      chk("after_reset_mb", mb, 980);

      repeat (5) @(posedge clock);
      chk("exp_a_drained", exp_a.size(), 0);
      chk("exp_b_drained", exp_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
